// File: rtl/fxp_pkg.sv
// Shared widths, saturation constants and accumulator state for fixed-point blocks.
// Pure declarations: no logic, no latency.
// No flow control of its own; users handle backpressure.
package fxp_pkg;

  // Accumulator occupancy: EMPTY means the next term starts a fresh group.
  typedef enum logic {
    ACC_EMPTY = 1'b0,
    ACC_RUN   = 1'b1
  } acc_state_e;

  localparam int SAT_MAXW = 64;

  // Full-precision product width.
  function automatic int calc_wp(input int wi1, input int wf1, input int wi2, input int wf2);
    return wi1 + wf1 + wi2 + wf2;
  endfunction

  // Fraction bits of the full-precision product.
  function automatic int calc_fp(input int wf1, input int wf2);
    return wf1 + wf2;
  endfunction

  // Accumulator width including guard bits.
  function automatic int calc_wa(input int wp, input int acc_g);
    return wp + acc_g;
  endfunction

  // Largest positive w-bit two's complement value (0 then all 1s).
  function automatic logic [SAT_MAXW-1:0] sat_max(input int w);
    return (SAT_MAXW'(1) << (w - 1)) - SAT_MAXW'(1);
  endfunction

  // Most negative w-bit two's complement value (1 then all 0s).
  function automatic logic [SAT_MAXW-1:0] sat_min(input int w);
    return SAT_MAXW'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/fxp_mac_if.sv
// Operand/result handshake bundle for the fixed-point MAC.
// Wires only, no latency.
// valid/ready on both sides; master drives operands and out_ready.
interface fxp_mac_if #(
  parameter int W1 = 9,
  parameter int W2 = 10,
  parameter int WO = 19
);
  logic          in_valid;
  logic          in_ready;
  logic [W1-1:0] in1;
  logic [W2-1:0] in2;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [WO-1:0] out;
  logic          OVF;

  modport master (
    output in_valid, in1, in2, in_last, out_ready,
    input  in_ready, out_valid, out, OVF
  );

  modport slave (
    input  in_valid, in1, in2, in_last, out_ready,
    output in_ready, out_valid, out, OVF
  );
endinterface

// File: rtl/fxp_resize.sv
// Resize a signed Q(.FP) value to Q(WIO.WFO): pad/drop fraction, saturate integer part.
// Combinational, zero latency.
// No flow control. Optional FXP_MAC_ROUND_EN: round half up before dropping LSBs.
module fxp_resize
  import fxp_pkg::*;
#(
  parameter int WA  = 23,
  parameter int FP  = 7,
  parameter int WIO = 12,
  parameter int WFO = 7
) (
  input  logic signed [WA-1:0]      val_i,
  output logic [WIO+WFO-1:0]        val_o,
  output logic                      sat_o
);
  localparam int WO  = WIO + WFO;
  localparam int PAD = (WFO > FP) ? (WFO - FP) : 0;
  // Two spare bits absorb the rounding carry so it is never lost before the range check.
  localparam int WW0 = WA + PAD + 2;
  localparam int WW  = (WW0 > WO + 1) ? WW0 : (WO + 1);

  logic signed [WW-1:0] ext;
  logic signed [WW-1:0] scaled;
  logic [WW-WO:0]       upper;

  assign ext = WW'(val_i);

  if (WFO >= FP) begin : g_pad
    assign scaled = ext <<< (WFO - FP);
  end else begin : g_drop
    localparam int D = FP - WFO;
`ifdef FXP_MAC_ROUND_EN
    logic signed [WW-1:0] biased;
    assign biased = ext + (WW'(1) <<< (D - 1));
    assign scaled = biased >>> D;
`else
    // Arithmetic shift truncates toward -inf.
    assign scaled = ext >>> D;
`endif
  end

  // Value fits when every bit above the output sign bit repeats the sign.
  assign upper = scaled[WW-1:WO-1];
  assign sat_o = ~((&upper) | ~(|upper));

  // Pass the fitting value, otherwise clamp toward the sign of the true value.
  always_comb begin
    val_o = scaled[WO-1:0];
    if (sat_o) begin
      val_o = scaled[WW-1] ? WO'(sat_min(WO)) : WO'(sat_max(WO));
    end
  end

endmodule

// File: rtl/fxp_mac.sv
// Signed fixed-point multiply-accumulate; one resized, saturated result per in_last group.
// Latency: last term accepted at edge k -> out_valid after edge k+1; 1 term/cycle.
// Backpressure: pending result not taken freezes the whole pipe and drops in_ready. Macro: FXP_MAC_ROUND_EN.
module fxp_mac
  import fxp_pkg::*;
#(
  parameter int WI1   = 5,
  parameter int WF1   = 4,
  parameter int WI2   = 7,
  parameter int WF2   = 3,
  parameter int WIO   = 12,
  parameter int WFO   = 7,
  parameter int ACC_G = 4
) (
  input  logic        clk,
  input  logic        rst,
  fxp_mac_if.slave    bus
);
  localparam int W1 = WI1 + WF1;
  localparam int W2 = WI2 + WF2;
  localparam int WP = calc_wp(WI1, WF1, WI2, WF2);
  localparam int FP = calc_fp(WF1, WF2);
  localparam int WA = calc_wa(WP, ACC_G);
  localparam int WO = WIO + WFO;

  logic                 stall;
  logic                 in_fire;
  logic signed [W1-1:0] op1;
  logic signed [W2-1:0] op2;

  // Stage 1 registers.
  logic signed [WP-1:0] p1_q, p1_d;
  logic                 v1_q, v1_d;
  logic                 last1_q, last1_d;

  // Stage 2 / accumulator / output registers.
  acc_state_e           state_q, state_d;
  logic signed [WA-1:0] acc_q, acc_d;
  logic                 acc_ovf_q, acc_ovf_d;
  logic [WO-1:0]        out_q, out_d;
  logic                 ovf_q, ovf_d;
  logic                 out_vld_q, out_vld_d;

  logic signed [WA-1:0] base;
  logic signed [WA-1:0] addend;
  logic signed [WA-1:0] sum;
  logic                 ovf_now;
  logic [WO-1:0]        fmt_val;
  logic                 fmt_sat;

  assign stall        = out_vld_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign in_fire      = bus.in_valid & ~stall;

  assign op1 = bus.in1;
  assign op2 = bus.in2;

  assign addend  = WA'(p1_q);
  assign base    = (state_q == ACC_EMPTY) ? '0 : acc_q;
  assign sum     = base + addend;
  // Two same-signed operands producing a differently signed sum wrapped.
  assign ovf_now = (base[WA-1] == addend[WA-1]) && (sum[WA-1] != base[WA-1]);

  fxp_resize #(
    .WA  (WA),
    .FP  (FP),
    .WIO (WIO),
    .WFO (WFO)
  ) u_resize (
    .val_i (sum),
    .val_o (fmt_val),
    .sat_o (fmt_sat)
  );

  // Stage 1 next state: capture the full-precision product of an accepted term.
  always_comb begin
    p1_d    = p1_q;
    v1_d    = v1_q;
    last1_d = last1_q;
    if (!stall) begin
      v1_d = in_fire;
      if (in_fire) begin
        p1_d    = WP'(op1) * WP'(op2);
        last1_d = bus.in_last;
      end
    end
  end

  // Stage 2 next state: accumulate, or close the group and present the result.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    out_vld_d = out_vld_q;
    if (!stall) begin
      // Either nothing was pending or it was just taken; reload below if a group closes.
      out_vld_d = 1'b0;
      if (v1_q) begin
        if (last1_q) begin
          out_d     = fmt_val;
          ovf_d     = fmt_sat | acc_ovf_q | ovf_now;
          out_vld_d = 1'b1;
          acc_d     = '0;
          acc_ovf_d = 1'b0;
          state_d   = ACC_EMPTY;
        end else begin
          acc_d     = sum;
          acc_ovf_d = acc_ovf_q | ovf_now;
          state_d   = ACC_RUN;
        end
      end
    end
  end

  // State registers; reset discards any partial group and pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q      <= '0;
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      state_q   <= ACC_EMPTY;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      p1_q      <= p1_d;
      v1_q      <= v1_d;
      last1_q   <= last1_d;
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out       = out_q;
  assign bus.OVF       = ovf_q;

endmodule

// File: tb/tb_fxp_mac.sv
// Randomized and directed bench for fxp_mac against an arithmetic reference model.
// Second instance with WFO=5 exercises the fraction-drop / rounding path.
module tb_fxp_mac;
  localparam int W1 = 9;
  localparam int W2 = 10;
  localparam int FP = 7;
  localparam int WA = 23;
  localparam int WO = 19;
  localparam int WO5 = 17;

  typedef struct {
    logic [63:0] val;
    bit          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fxp_mac_if #(.W1(W1), .W2(W2), .WO(WO))  m  ();
  fxp_mac_if #(.W1(W1), .W2(W2), .WO(WO5)) m5 ();

  fxp_mac dut (.clk(clk), .rst(rst), .bus(m));
  fxp_mac #(.WFO(5)) dut5 (.clk(clk), .rst(rst), .bus(m5));

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        exp_q[$];
  longint      run = 0;
  bit          run_ovf = 0;
  bit          in_fire = 0;
  bit          rand_rdy = 0;
  logic [63:0] last_out = '0;
  bit          last_ovf = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: exact sum in real LSB units, rescaled and clamped arithmetically.
  function automatic exp_t fmt(input longint r, input bit ovf_in, input int wfo, input int wo);
    exp_t   e;
    longint v;
    longint omax;
    longint omin;
    int     d;
    if (wfo >= FP) begin
      v = r * (longint'(1) << (wfo - FP));
    end else begin
      d = FP - wfo;
`ifdef FXP_MAC_ROUND_EN
      r = r + (longint'(1) << (d - 1));
`endif
      v = r >>> d;
    end
    omax  = (longint'(1) << (wo - 1)) - 1;
    omin  = -(longint'(1) << (wo - 1));
    e.ovf = ovf_in;
    if (v > omax) begin
      v = omax;
      e.ovf = 1'b1;
    end else if (v < omin) begin
      v = omin;
      e.ovf = 1'b1;
    end
    e.val = 64'(v) & ((64'd1 << wo) - 64'd1);
    return e;
  endfunction

  task automatic model_add(input logic [W1-1:0] a, input logic [W2-1:0] b, input bit l);
    logic signed [W1-1:0] sa;
    logic signed [W2-1:0] sb;
    longint amax;
    longint amin;
    sa   = a;
    sb   = b;
    amax = (longint'(1) << (WA - 1)) - 1;
    amin = -(longint'(1) << (WA - 1));
    run  = run + longint'(sa) * longint'(sb);
    if (run > amax || run < amin) begin
      run_ovf = 1'b1;
      run = longint'($signed(run[WA-1:0]));
    end
    if (l) begin
      exp_q.push_back(fmt(run, run_ovf, 7, WO));
      run = 0;
      run_ovf = 1'b0;
    end
  endtask

  // One clock: observe handshakes mid-cycle, then advance past the edge.
  task automatic cycle();
    exp_t e;
    bit   out_fire;
    @(negedge clk);
    in_fire  = m.in_valid && m.in_ready && !rst;
    out_fire = m.out_valid && m.out_ready && !rst;
    if (rst) begin
      run = 0;
      run_ovf = 1'b0;
      exp_q.delete();
    end else begin
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(m.out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out", 64'(m.out), e.val);
          chk("ovf", 64'(m.OVF), 64'(e.ovf));
          last_out = 64'(m.out);
          last_ovf = m.OVF;
        end
      end
      if (in_fire) model_add(m.in1, m.in2, m.in_last);
    end
    @(posedge clk);
    #1;
    if (rand_rdy) m.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [W1-1:0] a, input logic [W2-1:0] b, input bit l);
    int n;
    n = 0;
    m.in_valid = 1'b1;
    m.in1 = a;
    m.in2 = b;
    m.in_last = l;
    in_fire = 1'b0;
    while (!in_fire && n < 500) begin
      cycle();
      n++;
    end
    if (!in_fire) chk("send_timeout", 64'(in_fire), 64'd1);
    m.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    m.in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 500) begin
      cycle();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    exp_t        e5;
    bit          got;
    logic [63:0] held;
    logic [W1-1:0] a;
    logic [W2-1:0] b;
    int          glen;

    m.in_valid = 1'b0; m.in1 = '0; m.in2 = '0; m.in_last = 1'b0; m.out_ready = 1'b1;
    m5.in_valid = 1'b0; m5.in1 = '0; m5.in2 = '0; m5.in_last = 1'b0; m5.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_out_valid", 64'(m.out_valid), 64'd0);
    chk("rst_out", 64'(m.out), 64'd0);
    chk("rst_ovf", 64'(m.OVF), 64'd0);
    chk("rst_in_ready", 64'(m.in_ready), 64'd1);

    // Single term 1.5*2.0, latency of two edges
    send(9'h018, 10'h010, 1'b1);
    chk("lat_edge_k", 64'(m.out_valid), 64'd0);
    cycle();
    chk("lat_edge_k1", 64'(m.out_valid), 64'd1);
    drain();
    chk("single_val", last_out, 64'h00180);
    chk("single_ovf", 64'(last_ovf), 64'd0);

    // Dot product of four terms
    for (int i = 0; i < 4; i++) send(9'h018, 10'h010, i == 3);
    drain();
    chk("dot4_val", last_out, 64'h00600);
    chk("dot4_ovf", 64'(last_ovf), 64'd0);

    // Saturation from large positive products
    for (int i = 0; i < 4; i++) send(9'h0FF, 10'h1FF, i == 3);
    drain();
    chk("sat4_val", last_out, 64'h3FFFF);
    chk("sat4_ovf", 64'(last_ovf), 64'd1);
    for (int i = 0; i < 2; i++) send(9'h100, 10'h200, i == 1);
    drain();
    chk("sat2_val", last_out, 64'h3FFFF);
    chk("sat2_ovf", 64'(last_ovf), 64'd1);

    // Group longer than the guard bits cover: accumulator wraps, flag sticks
    for (int i = 0; i < 40; i++) send(9'h100, 10'h200, i == 39);
    drain();
    chk("accwrap_ovf", 64'(last_ovf), 64'd1);

    // Backpressure with input streaming
    m.out_ready = 1'b0;
    m.in_valid = 1'b1; m.in_last = 1'b1; m.in2 = 10'h010;
    m.in1 = 9'h008; cycle();
    m.in1 = 9'h010; cycle();
    m.in1 = 9'h018;
    held = 64'(m.out);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 64'(m.in_ready), 64'd0);
      cycle();
      chk("bp_out_hold", 64'(m.out), held);
    end
    m.out_ready = 1'b1;
    in_fire = 1'b0;
    for (int i = 0; i < 10 && !in_fire; i++) cycle();
    chk("bp_resume_accept", 64'(in_fire), 64'd1);
    drain();
    chk("bp_last_val", last_out, 64'h00180);

    // Reset mid-group, then a clean single term
    send(9'h018, 10'h010, 1'b0);
    send(9'h018, 10'h010, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_mid_out_valid", 64'(m.out_valid), 64'd0);
    send(9'h018, 10'h010, 1'b1);
    drain();
    chk("rst_mid_val", last_out, 64'h00180);

    // Fraction drop on the WFO=5 instance
    e5 = fmt(64'sd3, 1'b0, 5, WO5);
    m5.in_valid = 1'b1; m5.in1 = 9'h003; m5.in2 = 10'h001; m5.in_last = 1'b1;
    @(posedge clk); #1;
    m5.in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (m5.out_valid) begin
        got = 1'b1;
        chk("round_val", 64'(m5.out), e5.val);
        chk("round_ovf", 64'(m5.OVF), 64'(e5.ovf));
      end
    end
    chk("round_seen", 64'(got), 64'd1);
    @(posedge clk); #1;

    // Randomized groups with random gaps and random out_ready
    rand_rdy = 1'b1;
    for (int g = 0; g < 150; g++) begin
      glen = ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(1, 6);
      for (int t = 0; t < glen; t++) begin
        if ($urandom_range(0, 1) != 0) begin
          a = W1'($urandom);
          b = W2'($urandom);
        end else begin
          a = W1'($urandom_range(0, 31)) - W1'(16);
          b = W2'($urandom_range(0, 63)) - W2'(32);
        end
        send(a, b, t == glen - 1);
        if ($urandom_range(0, 3) == 0) cycle();
      end
    end
    rand_rdy = 1'b0;
    m.out_ready = 1'b1;
    drain();
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
